tcam_match_resolver: RTL and testbench
======================================

// Module: tcam_match_resolver
// PURPOSE
//  Consumer side of the ternary CAM search port. Captures the multi-hot
//  `matched` vector of one search and returns every matching address, lowest
//  first, one per accepted handshake. Sits between the TCAM and the lookup
//  client so that multiple hits are handed out serially, not collapsed.
// PARAMETERS
//  address_size  4  address width; entries = 1 << address_size (localparam)
// PORTS
//  clock          in   1             system clock, rising edge
//  reset          in   1             asynchronous, active-high
//  matched        in   entries       TCAM match lines; bit i = entry i hit
//  start          in   1             capture `matched`, begin resolution
//  busy           out  1             resolution in progress; start ignored
//  address        out  address_size  current hit address
//  address_valid  out  1             `address` is a valid hit
//  address_ready  in   1             client accepts `address` this cycle
//  done           out  1             one-cycle pulse: all hits delivered
//  none           out  1             one-cycle pulse with done: zero hits
//  match_count    out  address_size+1  hits in capture (MATCH_COUNT_EN only)
// BEHAVIOUR
//  - Reset (async): state IDLE, pending = 0; busy, address_valid, done, none = 0;
//    address = 0; match_count = 0.
//  - States: IDLE, SCAN, DONE.
//  - IDLE: on start=1 at edge k, pending <= matched; busy = 1 from k.
//    matched != 0 -> SCAN; matched == 0 -> DONE with none armed.
//  - SCAN: address = index of lowest set bit of pending; address_valid = 1.
//    First address visible after edge k (1-cycle latency from start).
//    On address_valid && address_ready: clear that bit; if it was the last
//    bit -> DONE, else next address presented next cycle (1 per cycle max).
//    Without ready: address and address_valid hold stable indefinitely.
//  - DONE: done = 1 (none = 1 if capture was zero) for exactly one cycle,
//    busy still 1; then IDLE, busy = 0. Earliest new start: the IDLE cycle.
//  - start while busy: ignored, no queuing. Changes on `matched` after
//    capture: ignored.
//  - All outputs derive from registers only; no input-to-output comb path.
//  - Reset mid-SCAN: pending discarded, outputs to reset values immediately.
//  - Full vector (all ones): addresses 0..entries-1 in order, no gaps.
// CONFIGURATION
//  MATCH_COUNT_EN defined: match_count <= popcount(matched) at capture,
//    held until next capture; value entries needs address_size+1 bits.
//  MATCH_COUNT_EN undefined: match_count port and popcount logic absent.
// STRUCTURE
//  - tcam_pkg.vh: state encodings (IDLE/SCAN/DONE localparams) and the
//    entries = 1 << address_size derivation, shared with the TCAM.
//  - Sub-module tcam_priority_encoder: combinational, parameterized by
//    address_size; outputs lowest set-bit index and an `any` flag.
// TESTING  (address_size = 4)
//  1. matched=16'h0012, start, ready=1 -> address 1, then 4 on next cycle,
//     then done pulse, none=0, busy low after done.
//  2. matched=16'h0012, ready=0 for 3 cycles -> address holds 1 with
//     valid=1; on ready=1, address 4 follows next cycle.
//  3. matched=16'h0000, start -> no address_valid; done=1 and none=1 in the
//     cycle after start, busy=0 the cycle after that.
//  4. matched=16'hFFFF, ready=1 -> addresses 0..15 on 16 consecutive cycles,
//     then done; with MATCH_COUNT_EN match_count=16.
//  5. start during SCAN with matched=16'h8000 -> ignored; original hits only.
//  6. reset asserted between hits -> valid, busy, done clear asynchronously;
//     next start after release resolves cleanly from IDLE.

Source files
------------

// File: rtl/tcam_match_resolver_pkg.sv
// Shared definitions for the TCAM match resolver: resolver state encoding and
// the address_size -> entries derivation used by the TCAM search path.
package tcam_match_resolver_pkg;

  localparam int unsigned TCAM_ADDR_SIZE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of TCAM entries addressed by an address of the given width.
  function automatic int unsigned tcam_entries(input int unsigned asz);
    return int'(32'd1 << asz);
  endfunction

endpackage

// File: rtl/tcam_match_resolver_priority_encoder.sv
// Combinational lowest-set-bit encoder over the TCAM match lines.
module tcam_match_resolver_priority_encoder
  import tcam_match_resolver_pkg::*;
#(
  parameter  int unsigned address_size = TCAM_ADDR_SIZE,
  localparam int unsigned entries      = tcam_entries(address_size)
) (
  input  logic [entries-1:0]      vec,
  output logic [address_size-1:0] index_c,
  output logic                    any_c
);

  always_comb begin
    index_c = '0;
    any_c   = 1'b0;
    for (int unsigned i = 0; i < entries; i++) begin
      if (vec[i] && !any_c) begin
        index_c = address_size'(i);
        any_c   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tcam_match_resolver.sv
// Serialises the hits of one TCAM search into lowest-first address handshakes.
// Optional MATCH_COUNT_EN adds a match_count output holding popcount(matched).
module tcam_match_resolver
  import tcam_match_resolver_pkg::*;
#(
  parameter  int unsigned address_size = TCAM_ADDR_SIZE,
  localparam int unsigned entries      = tcam_entries(address_size),
  localparam int unsigned count_w      = address_size + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [entries-1:0]      matched,
  input  logic                    start,
  output logic                    busy,
  output logic [address_size-1:0] address,
  output logic                    address_valid,
  input  logic                    address_ready,
  output logic                    done,
`ifdef MATCH_COUNT_EN
  output logic                    none,
  output logic [count_w-1:0]      match_count
`else
  output logic                    none
`endif
);

  state_e                  state_q, state_d;
  logic [entries-1:0]      pending_q, pending_d;
  logic [address_size-1:0] address_q, address_d;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    none_q, none_d;

  logic [entries-1:0]      pe_vec;
  logic [address_size-1:0] pe_index;
  logic                    pe_any;

  tcam_match_resolver_priority_encoder #(
    .address_size (address_size)
  ) u_pe (
    .vec     (pe_vec),
    .index_c (pe_index),
    .any_c   (pe_any)
  );

  // The encoder looks at the fresh capture in IDLE and at the post-handshake
  // remainder in SCAN, so the next address is ready to register on that edge.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    address_d = address_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    none_d    = 1'b0;
    pe_vec    = pending_q & ~(entries'(1) << address_q);

    case (state_q)
      ST_IDLE: begin
        pe_vec = matched;
        if (start) begin
          pending_d = matched;
          busy_d    = 1'b1;
          if (pe_any) begin
            state_d   = ST_SCAN;
            address_d = pe_index;
            valid_d   = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            none_d  = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (address_ready) begin
          pending_d = pe_vec;
          if (pe_any) begin
            address_d = pe_index;
          end else begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d   = ST_IDLE;
        pending_d = '0;
        busy_d    = 1'b0;
        valid_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      address_q <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      none_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      address_q <= address_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      none_q    <= none_d;
    end
  end

`ifdef MATCH_COUNT_EN
  logic [count_w-1:0] count_q, count_d, pop_c;

  always_comb begin
    pop_c = '0;
    for (int unsigned i = 0; i < entries; i++) begin
      pop_c = pop_c + count_w'(matched[i]);
    end
    count_d = count_q;
    if (state_q == ST_IDLE && start) begin
      count_d = pop_c;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign match_count = count_q;
`endif

  assign busy          = busy_q;
  assign address       = address_q;
  assign address_valid = valid_q;
  assign done          = done_q;
  assign none          = none_q;

endmodule

// File: tb/tb_tcam_match_resolver.sv
// Scoreboard bench for tcam_match_resolver (address_size = 4, 16 entries).
module tb_tcam_match_resolver;

  localparam int K_ADDR = 0;
  localparam int K_DONE = 1;

  typedef struct {
    int kind;
    int val;
    int cnt;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [15:0] matched;
  logic        start;
  logic        busy;
  logic [3:0]  address;
  logic        address_valid;
  logic        address_ready;
  logic        done;
  logic        none;
`ifdef MATCH_COUNT_EN
  logic [4:0]  match_count;
`endif

  exp_t exp_q[$];
  int   n_cmp;
  int   n_err;
  bit   stall_prev;
  int   stall_addr;

  tcam_match_resolver dut (
    .clock         (clock),
    .reset         (reset),
    .matched       (matched),
    .start         (start),
    .busy          (busy),
    .address       (address),
    .address_valid (address_valid),
    .address_ready (address_ready),
    .done          (done),
`ifdef MATCH_COUNT_EN
    .none          (none),
    .match_count   (match_count)
`else
    .none          (none)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: every set bit of the capture, ascending, then one done record.
  task automatic push_expected(input logic [15:0] m);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        e.kind = K_ADDR; e.val = i; e.cnt = 0;
        exp_q.push_back(e);
      end
    end
    e.kind = K_DONE;
    e.val  = (m == 16'h0) ? 1 : 0;
    e.cnt  = $countones(m);
    exp_q.push_back(e);
  endtask

  function automatic int lowest(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic logic pick_ready(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return 1'($urandom_range(0, 1));
      default: return (cyc <= 3) ? 1'b0 : 1'b1;
    endcase
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    stall_prev = 1'b0;
    stall_addr = 0;
    forever begin
      @(negedge clock);
      if (stall_prev) begin
        check("hold_valid", int'(address_valid), 1);
        check("hold_addr", int'(address), stall_addr);
      end
      stall_prev = 1'b0;
      if (address_valid) begin
        if (address_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_addr", int'(address_valid), 0);
          end else begin
            e = exp_q.pop_front();
            check("addr_kind", K_ADDR, e.kind);
            check("address", int'(address), e.val);
          end
        end else begin
          stall_prev = 1'b1;
          stall_addr = int'(address);
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", int'(done), 0);
        end else begin
          e = exp_q.pop_front();
          check("done_kind", K_DONE, e.kind);
          check("none", int'(none), e.val);
`ifdef MATCH_COUNT_EN
          check("match_count", int'(match_count), e.cnt);
`endif
        end
      end else if (none) begin
        check("none_without_done", int'(done), 1);
      end
    end
  end

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (busy && cyc < 200) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("idle_before_start", int'(busy), 0);
  endtask

  task automatic run_search(input logic [15:0] m, input int mode, input bit extra);
    int cyc;
    wait_idle();
    push_expected(m);
    matched       = m;
    start         = 1'b1;
    address_ready = 1'b1;
    @(posedge clock); #1;
    start   = 1'b0;
    matched = 16'($urandom);
    if (m != 16'h0) begin
      check("first_valid", int'(address_valid), 1);
      check("first_addr", int'(address), lowest(m));
    end else begin
      check("zero_valid", int'(address_valid), 0);
      check("zero_done", int'(done), 1);
      check("zero_none", int'(none), 1);
    end
    check("busy_after_start", int'(busy), 1);
    cyc = 1;
    while (busy && cyc < 200) begin
      address_ready = pick_ready(mode, cyc);
      if (extra && cyc == 2) begin
        start   = 1'b1;
        matched = 16'h8000;
      end
      @(posedge clock); #1;
      start = 1'b0;
      cyc++;
    end
    check("busy_timeout", int'(busy), 0);
    check("queue_drained", exp_q.size(), 0);
    if (mode == 0 && !extra) check("latency", cyc, $countones(m) + 2);
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    reset         = 1'b1;
    matched       = 16'h0;
    start         = 1'b0;
    address_ready = 1'b0;
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(address_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_none", int'(none), 0);
    check("rst_addr", int'(address), 0);
`ifdef MATCH_COUNT_EN
    check("rst_count", int'(match_count), 0);
`endif
    reset = 1'b0;
    @(posedge clock); #1;

    run_search(16'h0012, 0, 1'b0);
    run_search(16'h0012, 2, 1'b0);
    run_search(16'h0000, 0, 1'b0);
    run_search(16'hFFFF, 0, 1'b0);
    run_search(16'h0012, 2, 1'b1);
    run_search(16'h8001, 0, 1'b0);

    // Asynchronous reset between hits of a three-hit search.
    wait_idle();
    push_expected(16'h0111);
    matched       = 16'h0111;
    start         = 1'b1;
    address_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    check("pre_reset_addr", int'(address), 4);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_valid", int'(address_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_addr", int'(address), 0);
`ifdef MATCH_COUNT_EN
    check("mid_rst_count", int'(match_count), 0);
`endif
    exp_q.delete();
    #1 reset = 1'b0;
    @(posedge clock); #1;
    run_search(16'h0420, 0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      logic [15:0] m;
      case ($urandom_range(0, 3))
        0:       m = 16'h0;
        1:       m = 16'($urandom);
        2:       m = 16'($urandom & $urandom & $urandom);
        default: m = 16'h1 << $urandom_range(0, 15);
      endcase
      run_search(m, 1, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clock);
    #1;
    check("final_queue", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
